phase_sequencer: RTL

//  Phase/run controller for the multi-phase processor core. Owns the phase counter (P0..P4)

---
 rtl/proc_pkg.sv | 24 ++
 rtl/exec_sync_edge.sv | 27 ++
 rtl/phase_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multi-phase core: run-state encodings and phase index names
// used by both the phase sequencer and the control decoder.
package proc_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int NUM_PHASES_DEF = 5;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_MEM    = 3;
    localparam int PH_WB     = 4;

    // A one-bit index is still needed when only two phases exist.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/exec_sync_edge.sv
// Brings the asynchronous exec button into the clk domain and emits a one-cycle pulse
// on each synchronised rising edge.
module exec_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/phase_sequencer.sv
// Phase/run controller: walks P0..P[N-1] per instruction, stalls fetch on memory,
// converts exec presses into start/stop requests and latches HALT on an HLT instruction.
module phase_sequencer
    import proc_pkg::*;
#(
    parameter int NUM_PHASES  = NUM_PHASES_DEF,
    parameter int WAIT_PHASE  = PH_FETCH,
    parameter int HLT_PHASE   = PH_DECODE,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exec,
    input  logic                  step_mode,
    input  logic                  hlt_decoded,
    input  logic                  mem_rdy,
    output logic [NUM_PHASES-1:0] phase,
    output logic                  p0,
    output logic                  running,
    output logic                  stop_flag,
    output logic [CNT_W-1:0]      instr_count,
    output state_t                dbg_state
);

    localparam int IDX_W = idx_width(NUM_PHASES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
    localparam logic [IDX_W-1:0] WAIT_IDX = IDX_W'(WAIT_PHASE);
    localparam logic [IDX_W-1:0] HLT_IDX  = IDX_W'(HLT_PHASE);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_running;
    logic             r_stop_flag;
    logic             r_stop_req;
    logic [CNT_W-1:0] r_count;

    logic w_exec_edge;
    logic w_stall;
    logic w_halt;
    logic w_last;

    exec_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_exec_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (exec),
        .o_edge  (w_exec_edge)
    );

    always_comb begin
        w_stall = (r_idx == WAIT_IDX) && !mem_rdy;
        w_halt  = (r_idx == HLT_IDX) && hlt_decoded;
        w_last  = (r_idx == LAST_IDX);
    end

    // Halt outranks the memory stall so WAIT_PHASE may equal HLT_PHASE; completion
    // waits on mem_rdy too in case the fetch phase is also the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_STOP;
            r_idx       <= '0;
            r_running   <= 1'b0;
            r_stop_flag <= 1'b0;
            r_stop_req  <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    r_idx      <= '0;
                    r_stop_req <= 1'b0;
                    if (w_exec_edge) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_halt) begin
                        r_state     <= ST_HALT;
                        r_running   <= 1'b0;
                        r_stop_flag <= 1'b1;
                        r_idx       <= '0;
                        r_stop_req  <= 1'b0;
                    end else if (w_stall) begin
                        r_stop_req <= r_stop_req | w_exec_edge;
                    end else if (w_last) begin
                        r_count <= r_count + CNT_W'(1);
                        r_idx   <= '0;
                        if (r_stop_req || w_exec_edge || step_mode) begin
                            r_state    <= ST_STOP;
                            r_running  <= 1'b0;
                            r_stop_req <= 1'b0;
                        end
                    end else begin
                        r_idx      <= r_idx + IDX_W'(1);
                        r_stop_req <= r_stop_req | w_exec_edge;
                    end
                end
                ST_HALT: begin
                    r_idx <= '0;
                end
                default: begin
                    r_state     <= ST_STOP;
                    r_idx       <= '0;
                    r_running   <= 1'b0;
                    r_stop_flag <= 1'b0;
                    r_stop_req  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        phase = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            phase[i] = (r_idx == IDX_W'(i));
        end
    end

    assign p0          = (r_idx == '0);
    assign running     = r_running;
    assign stop_flag   = r_stop_flag;
    assign instr_count = r_count;
    assign dbg_state   = r_state;

endmodule
